j1_boot_arbiter: RTL and testbench

Owns the J1 program/data RAM write port and the CPU reset line.
- At power-up it passes the UFM boot-copier's word stream into RAM and holds the CPU in reset until the copy finishes or times out.
- Afterwards it arbitrates the write port between the CPU and a host loader (UART/debug), including a host-requested halt-and-reload cycle.
- It also maintains a 16-bit additive checksum of the boot image.

---
 rtl/j1_boot_arbiter_if.sv | 44 ++++
 rtl/j1_boot_arbiter.sv | 156 +++++++++++++++
 tb/tb_j1_boot_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_boot_arbiter_if.sv
// Bus bundle for the J1 boot arbiter: boot-copier, CPU and host write
// sources on one side, RAM write port and status on the other.
interface j1_boot_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] ld_adr;
  logic              ld_wr;
  logic              ld_done;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wr;
  logic              host_req;
  logic [ADDR_W-1:0] host_adr;
  logic [DATA_W-1:0] host_data;
  logic              host_halt;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              cpu_rst_n;
  logic              host_ack;
  logic              booted;
  logic              boot_err;
  logic [15:0]       checksum;
  logic [1:0]        state;

  // The arbiter sees the write sources as inputs and drives the RAM/status side.
  modport slave (
    input  ld_data, ld_adr, ld_wr, ld_done,
    input  cpu_adr, cpu_data, cpu_wr,
    input  host_req, host_adr, host_data, host_halt,
    output ram_adr, ram_data, ram_we,
    output cpu_rst_n, host_ack, booted, boot_err, checksum, state
  );

  modport master (
    output ld_data, ld_adr, ld_wr, ld_done,
    output cpu_adr, cpu_data, cpu_wr,
    output host_req, host_adr, host_data, host_halt,
    input  ram_adr, ram_data, ram_we,
    input  cpu_rst_n, host_ack, booted, boot_err, checksum, state
  );
endinterface

// File: rtl/j1_boot_arbiter.sv
// Owns the J1 RAM write port and CPU reset: boot copy, reset release,
// CPU/host arbitration and host halt-and-reload, plus a boot-image checksum.
module j1_boot_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 16,
  parameter int BOOT_TIMEOUT = 524288,
  parameter int RST_HOLD     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  j1_boot_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam int TIMER_W = (BOOT_TIMEOUT > 2) ? $clog2(BOOT_TIMEOUT) : 1;
  localparam int HOLD_W  = $clog2(RST_HOLD + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BOOT_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);

  state_t             state_q, state_nxt;
  logic [TIMER_W-1:0] timer_q, timer_nxt;
  logic [HOLD_W-1:0]  hold_q, hold_nxt;
  logic [ADDR_W-1:0]  ram_adr_q, ram_adr_nxt;
  logic [DATA_W-1:0]  ram_data_q, ram_data_nxt;
  logic               ram_we_q, ram_we_nxt;
  logic               cpu_rst_q, cpu_rst_nxt;
  logic               ack_q, ack_nxt;
  logic               booted_q, booted_nxt;
  logic               err_q, err_nxt;
  logic [15:0]        sum_q, sum_nxt;
  logic               host_grant;

  // A host word is only granted outside the ack cycle, so a held request
  // costs at least two cycles per word.
  assign host_grant = bus.host_req && !ack_q;

  always_comb begin
    state_nxt    = state_q;
    timer_nxt    = timer_q;
    hold_nxt     = hold_q;
    ram_adr_nxt  = ram_adr_q;
    ram_data_nxt = ram_data_q;
    ram_we_nxt   = 1'b0;
    cpu_rst_nxt  = cpu_rst_q;
    ack_nxt      = 1'b0;
    booted_nxt   = booted_q;
    err_nxt      = err_q;
    sum_nxt      = sum_q;

    unique case (state_q)
      ST_BOOT: begin
        timer_nxt = timer_q + 1'b1;
        if (bus.ld_wr) begin
          ram_we_nxt   = 1'b1;
          ram_adr_nxt  = bus.ld_adr;
          ram_data_nxt = bus.ld_data;
          sum_nxt      = sum_q + 16'(bus.ld_data);
        end
        // A finished copy beats a coincident timeout.
        if (bus.ld_done) begin
          state_nxt = ST_RELEASE;
          hold_nxt  = '0;
        end else if (timer_q == TIMER_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
          hold_nxt  = '0;
        end
      end

      ST_RELEASE: begin
        if (hold_q == HOLD_LAST) begin
          state_nxt   = ST_RUN;
          cpu_rst_nxt = 1'b1;
          booted_nxt  = 1'b1;
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.cpu_wr) begin
          ram_we_nxt   = 1'b1;
          ram_adr_nxt  = bus.cpu_adr;
          ram_data_nxt = bus.cpu_data;
        end else if (host_grant) begin
          ram_we_nxt   = 1'b1;
          ram_adr_nxt  = bus.host_adr;
          ram_data_nxt = bus.host_data;
          ack_nxt      = 1'b1;
        end
        if (bus.host_halt) begin
          state_nxt   = ST_HALT;
          cpu_rst_nxt = 1'b0;
        end
      end

      ST_HALT: begin
        if (host_grant) begin
          ram_we_nxt   = 1'b1;
          ram_adr_nxt  = bus.host_adr;
          ram_data_nxt = bus.host_data;
          ack_nxt      = 1'b1;
        end
        if (!bus.host_halt) begin
          state_nxt = ST_RELEASE;
          hold_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_BOOT;
      timer_q    <= '0;
      hold_q     <= '0;
      ram_adr_q  <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      cpu_rst_q  <= 1'b0;
      ack_q      <= 1'b0;
      booted_q   <= 1'b0;
      err_q      <= 1'b0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      timer_q    <= timer_nxt;
      hold_q     <= hold_nxt;
      ram_adr_q  <= ram_adr_nxt;
      ram_data_q <= ram_data_nxt;
      ram_we_q   <= ram_we_nxt;
      cpu_rst_q  <= cpu_rst_nxt;
      ack_q      <= ack_nxt;
      booted_q   <= booted_nxt;
      err_q      <= err_nxt;
      sum_q      <= sum_nxt;
    end
  end

  assign bus.ram_adr   = ram_adr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.cpu_rst_n = cpu_rst_q;
  assign bus.host_ack  = ack_q;
  assign bus.booted    = booted_q;
  assign bus.boot_err  = err_q;
  assign bus.checksum  = sum_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_j1_boot_arbiter.sv
// Scoreboard bench for j1_boot_arbiter: expected RAM writes are queued at
// stimulus time and matched against ram_we pulses by a monitor.
module tb_j1_boot_arbiter;
  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 16;
  localparam int BOOT_TIMEOUT = 64;
  localparam int RST_HOLD     = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  j1_boot_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  j1_boot_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BOOT_TIMEOUT(BOOT_TIMEOUT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
    int                cyc;
    bit                host;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;
  int  base = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every ram_we pulse must match the oldest queued write, including its
  // cycle when known and whether it carries a host ack.
  always @(posedge clk) begin
    edge_cnt++;
    #1;
    if (bus.ram_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_we", 32'(bus.ram_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_adr", 32'(bus.ram_adr), 32'(mon_e.adr));
        checkOutput("wr_data", 32'(bus.ram_data), 32'(mon_e.data));
        if (mon_e.cyc >= 0) checkOutput("wr_cycle", 32'(edge_cnt), 32'(mon_e.cyc));
        checkOutput("wr_ack", 32'(bus.host_ack), 32'(mon_e.host));
      end
    end else if (bus.host_ack) begin
      checkOutput("stray_ack", 32'(bus.host_ack), 32'd0);
    end
  end

  task automatic check_zero(input string tag);
    checkOutput({tag, "_state"}, 32'(bus.state), 32'd0);
    checkOutput({tag, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    checkOutput({tag, "_ram_adr"}, 32'(bus.ram_adr), 32'd0);
    checkOutput({tag, "_ram_data"}, 32'(bus.ram_data), 32'd0);
    checkOutput({tag, "_host_ack"}, 32'(bus.host_ack), 32'd0);
    checkOutput({tag, "_booted"}, 32'(bus.booted), 32'd0);
    checkOutput({tag, "_boot_err"}, 32'(bus.boot_err), 32'd0);
    checkOutput({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
  endtask

  // Reset asserts mid-cycle and releases on a falling edge; base marks edge 0.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    bus.ld_data = '0;  bus.ld_adr = '0;  bus.ld_wr = 1'b0;  bus.ld_done = 1'b0;
    bus.cpu_adr = '0;  bus.cpu_data = '0; bus.cpu_wr = 1'b0;
    bus.host_req = 1'b0; bus.host_adr = '0; bus.host_data = '0; bus.host_halt = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    base = edge_cnt;
  endtask

  task automatic wait_until(input int rel);
    for (int i = 0; i < 1000 && (edge_cnt - base) < rel; i++) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] data,
                               input bit expect_wr);
    bus.ld_wr = 1'b1;
    bus.ld_adr = adr;
    bus.ld_data = data;
    if (expect_wr) exp_q.push_back('{adr, data, edge_cnt + 1, 1'b0});
    @(negedge clk);
    bus.ld_wr = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] data,
                           input bit expect_wr);
    bus.cpu_wr = 1'b1;
    bus.cpu_adr = adr;
    bus.cpu_data = data;
    if (expect_wr) exp_q.push_back('{adr, data, edge_cnt + 1, 1'b0});
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] data,
                            output int ack_edge);
    bus.host_req = 1'b1;
    bus.host_adr = adr;
    bus.host_data = data;
    exp_q.push_back('{adr, data, -1, 1'b1});
    ack_edge = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        ack_edge = edge_cnt;
        break;
      end
    end
    bus.host_req = 1'b0;
    checkOutput("host_ack_seen", 32'(ack_edge >= 0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, ae, hb;
    logic [15:0] sum;
    logic [DATA_W-1:0] d;

    // Normal boot: three words, done, then RST_HOLD cycles of held reset.
    do_reset("rst0");
    applyStimulus(11'd0, 16'h0001, 1'b1);
    applyStimulus(11'd1, 16'h0010, 1'b1);
    applyStimulus(11'd2, 16'h0100, 1'b1);
    checkOutput("boot_state", 32'(bus.state), 32'd0);
    bus.ld_done = 1'b1;
    @(negedge clk);
    checkOutput("rel_state", 32'(bus.state), 32'd1);
    checkOutput("rel_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    wait_until(19);
    checkOutput("rel_hold_state", 32'(bus.state), 32'd1);
    checkOutput("rel_hold_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    wait_until(20);
    checkOutput("run_state", 32'(bus.state), 32'd2);
    checkOutput("run_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    checkOutput("run_booted", 32'(bus.booted), 32'd1);
    checkOutput("run_boot_err", 32'(bus.boot_err), 32'd0);
    checkOutput("boot_checksum", 32'(bus.checksum), 32'h0111);

    // RUN traffic: CPU write, ignored boot-copier write, host write.
    cpu_write(11'd20, 16'h1234, 1'b1);
    applyStimulus(11'd30, 16'hBEEF, 1'b0);
    host_write(11'd9, 16'h0F0F, ae);
    @(negedge clk);

    // CPU and host collide: CPU first, host one cycle later with its ack.
    bus.cpu_wr = 1'b1; bus.cpu_adr = 11'd5; bus.cpu_data = 16'hAAAA;
    bus.host_req = 1'b1; bus.host_adr = 11'd7; bus.host_data = 16'h5555;
    exp_q.push_back('{11'd5, 16'hAAAA, edge_cnt + 1, 1'b0});
    exp_q.push_back('{11'd7, 16'h5555, edge_cnt + 2, 1'b1});
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    checkOutput("conflict_no_ack_yet", 32'(bus.host_ack), 32'd0);
    @(negedge clk);
    checkOutput("conflict_ack", 32'(bus.host_ack), 32'd1);
    bus.host_req = 1'b0;
    @(negedge clk);
    checkOutput("conflict_ack_drop", 32'(bus.host_ack), 32'd0);
    checkOutput("run_checksum_frozen", 32'(bus.checksum), 32'h0111);

    // Halt and reload.
    bus.host_halt = 1'b1;
    @(negedge clk);
    checkOutput("halt_state", 32'(bus.state), 32'd3);
    checkOutput("halt_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    cpu_write(11'd3, 16'h3333, 1'b0);
    host_write(11'd40, 16'h00A1, a1);
    host_write(11'd41, 16'h00A2, a2);
    checkOutput("halt_ack_gap", 32'((a2 - a1) >= 2), 32'd1);
    bus.host_halt = 1'b0;
    hb = edge_cnt;
    @(negedge clk);
    checkOutput("reload_state", 32'(bus.state), 32'd1);
    base = hb;
    wait_until(16);
    checkOutput("reload_hold_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    wait_until(17);
    checkOutput("reload_state_run", 32'(bus.state), 32'd2);
    checkOutput("reload_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    checkOutput("reload_checksum", 32'(bus.checksum), 32'h0111);
    checkOutput("reload_booted", 32'(bus.booted), 32'd1);

    // Host grant coincident with halt still completes.
    bus.host_req = 1'b1; bus.host_adr = 11'd50; bus.host_data = 16'h5A5A;
    bus.host_halt = 1'b1;
    exp_q.push_back('{11'd50, 16'h5A5A, edge_cnt + 1, 1'b1});
    @(negedge clk);
    checkOutput("grant_halt_state", 32'(bus.state), 32'd3);
    checkOutput("grant_halt_ack", 32'(bus.host_ack), 32'd1);
    bus.host_req = 1'b0;
    bus.host_halt = 1'b0;
    @(negedge clk);

    // Timeout boot.
    do_reset("rst1");
    wait_until(63);
    checkOutput("to_pre_state", 32'(bus.state), 32'd0);
    checkOutput("to_pre_err", 32'(bus.boot_err), 32'd0);
    wait_until(64);
    checkOutput("to_state", 32'(bus.state), 32'd1);
    checkOutput("to_err", 32'(bus.boot_err), 32'd1);
    wait_until(79);
    checkOutput("to_hold_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    wait_until(80);
    checkOutput("to_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
    checkOutput("to_run_state", 32'(bus.state), 32'd2);
    applyStimulus(11'd1, 16'h0077, 1'b0);
    @(negedge clk);
    checkOutput("to_checksum", 32'(bus.checksum), 32'd0);

    // Checksum wrap, then ld_done with a write on the timeout cycle.
    do_reset("rst2");
    applyStimulus(11'd10, 16'hFFFF, 1'b1);
    applyStimulus(11'd11, 16'h0002, 1'b1);
    checkOutput("wrap_checksum", 32'(bus.checksum), 32'h0001);
    wait_until(63);
    bus.ld_done = 1'b1;
    applyStimulus(11'd12, 16'h0005, 1'b1);
    checkOutput("tie_state", 32'(bus.state), 32'd1);
    checkOutput("tie_err", 32'(bus.boot_err), 32'd0);
    checkOutput("tie_checksum", 32'(bus.checksum), 32'h0006);

    // Reset mid-boot after a burst of words, then a fresh boot.
    do_reset("rst3");
    sum = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      d = DATA_W'($urandom);
      sum = sum + 16'(d);
      applyStimulus(ADDR_W'(i), d, 1'b1);
    end
    checkOutput("burst_checksum", 32'(bus.checksum), 32'(sum));
    do_reset("rst4");
    applyStimulus(11'd0, 16'h1234, 1'b1);
    applyStimulus(11'd1, 16'h0001, 1'b1);
    checkOutput("fresh_checksum", 32'(bus.checksum), 32'h1235);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
